// File: rtl/weight_loader_pkg.sv
// Shared widths and FSM encoding for the weight loader.
package weight_loader_pkg;

  localparam int unsigned WL_ADDR_W     = 16;
  localparam int unsigned WL_DATA_W     = 32;
  localparam int unsigned WL_CNT_W      = 12;
  localparam int unsigned WL_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } wl_state_e;

endpackage

// File: rtl/weight_fifo2.sv
// Two-entry FIFO holding returned SRAM words (payload + last flag) in issue order.
module weight_fifo2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [1:0][WIDTH-1:0] r_mem;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= 2'(r_count + 2'd1);
        2'b01:   r_count <= 2'(r_count - 2'd1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/weight_loader.sv
// Streams a run of 32-bit weight words from a synchronous SRAM into a
// valid/ready sink, keeping at most two words buffered or in flight.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = WL_ADDR_W,
  parameter int unsigned DATA_W = WL_DATA_W,
  parameter int unsigned CNT_W  = WL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_q,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last
);

  localparam int unsigned FIFO_W = DATA_W + 1;

  wl_state_e         r_state;
  wl_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done_empty;

  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_accept;
  logic              w_empty_req;
  logic              w_pop;
  logic              w_credit_ok;
  logic [2:0]        w_used;
  logic [1:0]        w_fifo_count;
  logic [FIFO_W-1:0] w_head;
  logic              w_fifo_valid;

  // Credits: buffered words plus the word returning this cycle, less any word leaving now.
  assign w_pop       = w_fifo_valid && w_ready;
  assign w_used      = 3'(w_fifo_count) + 3'(r_inflight);
  assign w_credit_ok = (3'(w_used - 3'(w_pop)) < 3'(WL_FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    w_issue_last = (r_issued == CNT_W'(r_num - CNT_W'(1)));
    w_accept     = 1'b0;
    w_empty_req  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            w_empty_req = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_issue_last = (num_words == CNT_W'(1));
            w_state_nxt  = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (r_issued == r_num) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_issue_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_next_addr     <= '0;
      r_hold_addr     <= '0;
      r_num           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done_empty    <= 1'b0;
    end else begin
      r_done_empty    <= w_empty_req;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_issue_last;
      if (w_accept) begin
        r_num <= num_words;
      end
      if (w_issue) begin
        r_hold_addr <= w_issue_addr;
        r_next_addr <= ADDR_W'(w_issue_addr + ADDR_W'(4));
        r_issued    <= w_accept ? CNT_W'(1) : CNT_W'(r_issued + CNT_W'(1));
      end
    end
  end

  // SRAM samples the address at the end of the issue cycle; data returns the next cycle.
  weight_fifo2 #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, sram_q}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign sram_wen  = 1'b0;
  assign sram_addr = w_issue ? w_issue_addr : r_hold_addr;
  assign busy      = (r_state != ST_IDLE);
  assign w_valid   = w_fifo_valid;
  assign w_data    = w_head[DATA_W-1:0];
  assign w_last    = w_fifo_valid && w_head[DATA_W];
  assign done      = r_done_empty || ((r_state == ST_DRAIN) && w_pop && w_last);

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: stimulus queues expected addresses/words,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [11:0] num_words;
  logic        busy;
  logic        done;
  logic        sram_wen;
  logic [15:0] sram_addr;
  logic [31:0] sram_q;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        w_last;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_addr [$];
  logic [32:0] exp_word [$];

  bit rdy_mode = 1'b0;
  logic [31:0] h_a [4];
  logic [31:0] h_b [3];

  always #5 clk = ~clk;

  weight_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_q    (sram_q),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last)
  );

  // SRAM model: byte k of word at a is (a[7:0]+k) ^ a[15:8].
  function automatic logic [31:0] sram_word(input logic [15:0] a);
    return {8'(a[7:0] + 8'd3) ^ a[15:8], 8'(a[7:0] + 8'd2) ^ a[15:8],
            8'(a[7:0] + 8'd1) ^ a[15:8], a[7:0] ^ a[15:8]};
  endfunction

  always @(posedge clk) sram_q <= sram_word(sram_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [31:0] d, input bit last);
    exp_addr.push_back(a);
    exp_word.push_back({last, d});
  endtask

  task automatic push_model(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_exp(16'(base + 16'(4 * i)), sram_word(16'(base + 16'(4 * i))), (i == n - 1));
    end
  endtask

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
  initial begin
    int idx;
    idx = 0;
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_mode) w_ready = 1'b1;
      else w_ready = ((idx % 4) == 0) || ((idx % 4) == 3);
      idx++;
    end
  end

  // Monitor: address order, word order/content, stall stability, credit bound.
  initial begin
    logic [15:0] prev_addr;
    logic        held;
    logic [32:0] held_word;
    int          n_issued;
    int          n_xfer;
    prev_addr = '0;
    held = 1'b0;
    held_word = '0;
    n_issued = 0;
    n_xfer = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_addr = sram_addr;
        held = 1'b0;
        n_issued = 0;
        n_xfer = 0;
      end else begin
        if (sram_addr !== prev_addr) begin
          n_issued++;
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL addr_unexpected act=0x%0h exp=none", sram_addr);
          end else begin
            chk("sram_addr", 64'(sram_addr), 64'(exp_addr.pop_front()));
          end
          prev_addr = sram_addr;
        end
        if (held) begin
          chk("stall_valid", 64'(w_valid), 64'd1);
          chk("stall_word", 64'({w_last, w_data}), 64'(held_word));
        end
        if (w_valid && w_ready) begin
          n_xfer++;
          if (exp_word.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected act=0x%0h exp=none", {w_last, w_data});
          end else begin
            chk("word", 64'({w_last, w_data}), 64'(exp_word.pop_front()));
          end
        end
        if (sram_addr !== 16'hxxxx && (n_issued - n_xfer) > 2) begin
          checks++;
          errors++;
          $display("FAIL credit act=%0d exp<=2", n_issued - n_xfer);
        end else if (n_issued != 0) begin
          checks++;
        end
        held = w_valid && !w_ready;
        held_word = {w_last, w_data};
      end
    end
  end

  task automatic run_req(input logic [15:0] base, input logic [11:0] n, input bit lat,
                         input bit intrude, input string tag);
    int  k;
    bit  got;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    num_words = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 16'h7770;
    num_words = 12'd0;
    if (lat) begin
      chk({tag, "_lat_c1"}, 64'(w_valid), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_lat_c2"}, 64'(w_valid), 64'd1);
    end
    if (intrude) begin
      @(posedge clk);
      #1;
      chk({tag, "_busy_at_intrude"}, 64'(busy), 64'd1);
      start = 1'b1;
      base_addr = 16'h0800;
      num_words = 12'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      num_words = 12'd0;
    end
    got = 1'b0;
    k = 0;
    while (k < 300 && !got) begin
      @(negedge clk);
      if (done) got = 1'b1;
      k++;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (n == 12'd0) chk({tag, "_done_cycle"}, 64'(k), 64'd1);
    else chk({tag, "_done_with_last"}, 64'(w_valid && w_ready && w_last), 64'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_words_left"}, 64'(exp_word.size()), 64'd0);
    chk({tag, "_addrs_left"}, 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    int k;
    int xf;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    h_a = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    h_b = '{32'h04050607, 32'h00010203, 32'h03020100};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_w_last", 64'(w_last), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_wen", 64'(sram_wen), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) push_exp(16'(16'h0010 + 16'(4 * i)), h_a[i], (i == 3));
    run_req(16'h0010, 12'd4, 1'b1, 1'b0, "basic4");

    run_req(16'h0040, 12'd0, 1'b0, 1'b0, "empty");
    chk("empty_addr_held", 64'(sram_addr), 64'h001C);
    chk("empty_w_valid", 64'(w_valid), 64'd0);

    for (int i = 0; i < 3; i++) push_exp(16'(16'hFFF8 + 16'(4 * i)), h_b[i], (i == 2));
    run_req(16'hFFF8, 12'd3, 1'b0, 1'b0, "wrap3");

    rdy_mode = 1'b1;
    push_model(16'h0300, 8);
    run_req(16'h0300, 12'd8, 1'b0, 1'b0, "stall8");
    rdy_mode = 1'b0;

    push_model(16'h0400, 5);
    run_req(16'h0400, 12'd5, 1'b0, 1'b1, "ignore");

    push_model(16'h0500, 1);
    run_req(16'h0500, 12'd1, 1'b0, 1'b0, "single");

    push_model(16'h0200, 6);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 16'h0200;
    num_words = 12'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_words = 12'd0;
    xf = 0;
    k = 0;
    while (k < 50 && xf < 2) begin
      @(negedge clk);
      if (w_valid && w_ready) xf++;
      k++;
    end
    chk("abort_two_words", 64'(xf), 64'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_w_valid", 64'(w_valid), 64'd0);
    chk("abort_w_last", 64'(w_last), 64'd0);
    chk("abort_sram_addr", 64'(sram_addr), 64'd0);
    exp_addr.delete();
    exp_word.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'(w_valid), 64'd0);
    push_model(16'h0100, 2);
    run_req(16'h0100, 12'd2, 1'b1, 1'b0, "after_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
